instruction_fetch_tag: RTL and testbench
========================================

INSTRUCTION_FETCH_TAG -- requirements
Module: instruction_fetch_tag

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first PC fetched after reset.
REQ-002 SHALL size all I$ geometry (ICACHE_NUM_WAYS, ICACHE_NUM_SET_BITS, tag width) from package defines.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low.
REQ-005 wb_do_branch  input  1  redirect request from WB.
REQ-006 wb_branch_target  input  32  redirect PC, word-aligned.
REQ-007 ifd_ift_inf  input  ifd_ift_inf_t  cache_miss, resume_fetch, update_tag_en[ways], update_tag_set, update_tag.
REQ-008 ift_valid  output  1  ift_ifd_inf holds a live fetch.
REQ-009 ift_ifd_inf  output  ift_ifd_inf_t  fetched_pc, tags_read[ways], valid_bits[ways].
REQ-010 flush_req  input  1  invalidate entire I$ (present only with ICACHE_FLUSH_EN).
REQ-011 flush_busy  output  1  invalidation walk in progress (present only with ICACHE_FLUSH_EN).

Function
REQ-012 SHALL hold pc_reg and state machine states RUN, MISS_WAIT, FLUSH (FLUSH only with ICACHE_FLUSH_EN).
REQ-013 Tag storage: one tag RAM per way, indexed by set_idx, 1-cycle registered read; valid bits in flops, ways x sets.
REQ-014 RUN, no miss, no branch: read tags/valids at pc_reg.set_idx; next cycle ift_valid=1, fetched_pc=pc_reg; pc_reg += 4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
REQ-015 Throughput: one fetch per cycle in RUN; tag-read-to-output latency exactly 1 cycle.
REQ-016 cache_miss=1 (same cycle as ift_valid): pc_reg <= ift_ifd_inf.fetched_pc (rewind); next cycle ift_valid=0; RUN -> MISS_WAIT.
REQ-017 MISS_WAIT: no tag reads, ift_valid=0, pc_reg held.
REQ-018 Any cycle, update_tag_en[w]=1: tag RAM w[update_tag_set] <= update_tag; valid[w][update_tag_set] <= 1.
REQ-019 MISS_WAIT, resume_fetch=1: -> RUN; re-fetch at pc_reg same cycle; ift_valid=1 next cycle.
REQ-020 wb_do_branch=1 in any state: pc_reg <= wb_branch_target; ift_valid=0 next cycle; state unchanged.
REQ-021 RUN, branch same cycle as cache_miss: branch wins; no MISS_WAIT entry; fetch resumes at target next cycle.
REQ-022 Branch in MISS_WAIT: new pc_reg retained; first fetch after resume_fetch at branch target.
REQ-023 Tag write and tag read to same set same cycle: read returns pre-write value (no bypass).

Reset
REQ-024 On rst low: state=RUN, pc_reg=RESET_PC, ift_valid=0, all valid bits=0, flush_busy=0; tag RAM contents undefined.
REQ-025 Reset mid-MISS_WAIT or mid-FLUSH SHALL abort immediately to REQ-024 state.
REQ-026 First ift_valid=1 SHALL occur on the second rising edge after rst deasserts, fetched_pc=RESET_PC.

Configuration
REQ-027 Macro ICACHE_FLUSH_EN defined: flush_req/flush_busy exist; flush_req=1 in RUN -> FLUSH, ift_valid=0.
REQ-028 FLUSH: set counter 0..2^ICACHE_NUM_SET_BITS-1, clears all ways' valid bits at one set per cycle, flush_busy=1; after last set -> RUN, fetch at pc_reg.
REQ-029 flush_req in MISS_WAIT SHALL be deferred until resume_fetch; branch during FLUSH updates pc_reg only.
REQ-030 Macro undefined: no flush ports, no FLUSH state, no counter logic.

Verification
REQ-031 Reset release, RESET_PC=32'h100, all hits forced -> ift_valid cycles 2,3,4 with fetched_pc 0x100, 0x104, 0x108.
REQ-032 Miss at 0x200 -> ift_valid=0 next cycle; update_tag_en=2'b01, set 0x10, then resume_fetch -> fetched_pc=0x200, valid_bits[0]=1, tags_read[0]=written tag.
REQ-033 wb_do_branch=1 with target 0x400 during MISS_WAIT -> after resume_fetch fetched_pc=0x400.
REQ-034 Branch to 0x800 same cycle as cache_miss at 0x300 -> no MISS_WAIT; next valid fetched_pc=0x800.
REQ-035 ICACHE_FLUSH_EN, 64 sets, flush_req pulse -> flush_busy high exactly 64 cycles; all valid_bits=0 on next fetch.
REQ-036 rst low mid-MISS_WAIT -> ift_valid=0, valid bits cleared, refetch from RESET_PC after release.

Source files
------------

// File: rtl/instruction_fetch_tag.sv
// instruction_fetch_tag: PC sequencer with per-way I$ tag RAMs and valid flops, 1-cycle tag lookup.
// Optional whole-cache invalidation walk enabled by defining ICACHE_FLUSH_EN.
package instruction_fetch_tag_pkg;
  localparam int ICACHE_NUM_WAYS     = 2;
  localparam int ICACHE_NUM_SET_BITS = 6;
  localparam int ICACHE_LINE_BITS    = 5;
  localparam int ICACHE_TAG_W        = 32 - ICACHE_NUM_SET_BITS - ICACHE_LINE_BITS;
  typedef struct packed {
    logic                           cache_miss;
    logic                           resume_fetch;
    logic [ICACHE_NUM_WAYS-1:0]     update_tag_en;
    logic [ICACHE_NUM_SET_BITS-1:0] update_tag_set;
    logic [ICACHE_TAG_W-1:0]        update_tag;
  } ifd_ift_inf_t;
  typedef struct packed {
    logic [31:0]                                    fetched_pc;
    logic [ICACHE_NUM_WAYS-1:0][ICACHE_TAG_W-1:0]   tags_read;
    logic [ICACHE_NUM_WAYS-1:0]                     valid_bits;
  } ift_ifd_inf_t;
endpackage

module instruction_fetch_tag
  import instruction_fetch_tag_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wb_do_branch,
  input  logic [31:0]  wb_branch_target,
  input  ifd_ift_inf_t ifd_ift_inf,
`ifdef ICACHE_FLUSH_EN
  input  logic         flush_req,
  output logic         flush_busy,
`endif
  output logic         ift_valid,
  output ift_ifd_inf_t ift_ifd_inf
);
  localparam int NS = 1 << ICACHE_NUM_SET_BITS;
  localparam logic [1:0] RUN       = 2'd0;
  localparam logic [1:0] MISS_WAIT = 2'd1;
`ifdef ICACHE_FLUSH_EN
  localparam logic [1:0] FLUSH     = 2'd2;
`endif
  logic [1:0] state_q, state_d;
  logic [31:0] pc_q, pc_d, fpc_q, fpc_d;
  logic vld_q, go_q, miss, resume, fetch;
  logic [ICACHE_NUM_SET_BITS-1:0] rd_set;
  logic [ICACHE_NUM_WAYS-1:0][NS-1:0] vbits_q;
  logic [ICACHE_NUM_WAYS-1:0] vrd_q;
  logic [ICACHE_NUM_WAYS-1:0][ICACHE_TAG_W-1:0] trd_q;
  logic [ICACHE_TAG_W-1:0] tram [ICACHE_NUM_WAYS][NS];

  assign rd_set = pc_q[ICACHE_LINE_BITS +: ICACHE_NUM_SET_BITS];
  // a live output only exists in RUN, so qualifying with vld_q confines misses to RUN
  assign miss   = ifd_ift_inf.cache_miss && vld_q && !wb_do_branch;
  assign resume = state_q == MISS_WAIT && ifd_ift_inf.resume_fetch;

`ifdef ICACHE_FLUSH_EN
  logic [ICACHE_NUM_SET_BITS-1:0] cnt_q;
  logic pend_q, pend_d, flush_go, flush_done;
  // a request seen while waiting on a miss is parked in pend_q until the refill resumes
  assign flush_go   = (flush_req || pend_q) && !miss && (state_q == RUN || resume);
  assign flush_done = state_q == FLUSH && &cnt_q;
  assign pend_d     = ((flush_req && state_q != FLUSH) || pend_q) && !flush_go;
  assign flush_busy = state_q == FLUSH;
  assign fetch      = go_q && !wb_do_branch && !miss && !flush_go &&
                      (state_q == RUN || resume || flush_done);
  assign state_d    = flush_go ? FLUSH : miss ? MISS_WAIT :
                      (resume || flush_done) ? RUN : state_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= state_q == FLUSH ? cnt_q + 1'b1 : '0;
      pend_q <= pend_d;
    end
`else
  assign fetch   = go_q && !wb_do_branch && !miss && (state_q == RUN || resume);
  assign state_d = miss ? MISS_WAIT : resume ? RUN : state_q;
`endif

  assign pc_d  = wb_do_branch ? wb_branch_target : miss ? fpc_q : fetch ? pc_q + 32'd4 : pc_q;
  assign fpc_d = fetch ? pc_q : fpc_q;

  // go_q delays the first lookup by one edge after reset release
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      fpc_q   <= RESET_PC;
      vld_q   <= 1'b0;
      go_q    <= 1'b0;
      vbits_q <= '0;
      vrd_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fpc_q   <= fpc_d;
      vld_q   <= fetch;
      go_q    <= 1'b1;
`ifdef ICACHE_FLUSH_EN
      if (state_q == FLUSH)
        for (int w = 0; w < ICACHE_NUM_WAYS; w++) vbits_q[w][cnt_q] <= 1'b0;
`endif
      for (int w = 0; w < ICACHE_NUM_WAYS; w++) begin
        if (ifd_ift_inf.update_tag_en[w]) vbits_q[w][ifd_ift_inf.update_tag_set] <= 1'b1;
        if (fetch) vrd_q[w] <= vbits_q[w][rd_set];
      end
    end

  // tag RAMs carry no reset; a same-set write is not bypassed to the read
  always_ff @(posedge clk)
    for (int w = 0; w < ICACHE_NUM_WAYS; w++) begin
      if (ifd_ift_inf.update_tag_en[w]) tram[w][ifd_ift_inf.update_tag_set] <= ifd_ift_inf.update_tag;
      if (fetch) trd_q[w] <= tram[w][rd_set];
    end

  assign ift_valid              = vld_q;
  assign ift_ifd_inf.fetched_pc = fpc_q;
  assign ift_ifd_inf.tags_read  = trd_q;
  assign ift_ifd_inf.valid_bits = vrd_q;
endmodule

// File: tb/tb_instruction_fetch_tag.sv
// tb_instruction_fetch_tag: directed scenarios plus randomized traffic against a
// cycle-level reference of the fetch/miss/branch/flush rules.
module tb_instruction_fetch_tag;
  import instruction_fetch_tag_pkg::*;
  localparam int NW = ICACHE_NUM_WAYS;
  localparam int NS = 1 << ICACHE_NUM_SET_BITS;
  localparam logic [31:0] RPC = 32'h100;
`ifdef ICACHE_FLUSH_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0, wb_do_branch = 1'b0;
  logic [31:0] wb_branch_target = '0;
  ifd_ift_inf_t ifd_ift_inf = '0;
  logic ift_valid;
  ift_ifd_inf_t ift_ifd_inf;
`ifdef ICACHE_FLUSH_EN
  logic flush_req = 1'b0, flush_busy;
`endif

  instruction_fetch_tag #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .wb_do_branch(wb_do_branch), .wb_branch_target(wb_branch_target),
    .ifd_ift_inf(ifd_ift_inf),
`ifdef ICACHE_FLUSH_EN
    .flush_req(flush_req), .flush_busy(flush_busy),
`endif
    .ift_valid(ift_valid), .ift_ifd_inf(ift_ifd_inf));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // reference: mode 0 = fetching, 1 = waiting on refill, 2 = invalidating
  int m_mode, m_cnt;
  logic [31:0] m_pc;
  bit m_started, m_pend;
  bit m_valid [NW][NS];
  logic [ICACHE_TAG_W-1:0] m_tag [NW][NS];
  bit e_vld;
  logic [31:0] e_pc;
  bit e_vb [NW];
  logic [ICACHE_TAG_W-1:0] e_tag [NW];

  function automatic int set_of(logic [31:0] a);
    return int'((a >> ICACHE_LINE_BITS) % NS);
  endfunction

  task automatic model_reset;
    m_mode = 0; m_cnt = 0; m_pc = RPC; m_started = 0; m_pend = 0; e_vld = 0;
    for (int w = 0; w < NW; w++) for (int s = 0; s < NS; s++) m_valid[w][s] = 0;
  endtask

  task automatic step(input bit br, input logic [31:0] tgt, input bit miss, input bit res,
                      input logic [NW-1:0] en, input logic [ICACHE_NUM_SET_BITS-1:0] st,
                      input logic [ICACHE_TAG_W-1:0] tg, input bit fl);
    bit miss_eff, fl_last, to_flush, fetch;
    logic [31:0] old_pc;
    int rs;
    wb_do_branch = br; wb_branch_target = tgt;
    ifd_ift_inf.cache_miss = miss; ifd_ift_inf.resume_fetch = res;
    ifd_ift_inf.update_tag_en = en; ifd_ift_inf.update_tag_set = st; ifd_ift_inf.update_tag = tg;
`ifdef ICACHE_FLUSH_EN
    flush_req = fl;
`endif
    miss_eff = miss && e_vld && !br;
    fl_last = m_mode == 2 && m_cnt == NS - 1;
    if (FE && fl && m_mode != 2) m_pend = 1;
    to_flush = m_pend && !miss_eff && (m_mode == 0 || (m_mode == 1 && res));
    fetch = m_started && !br && !miss_eff && !to_flush && (m_mode == 0 || (m_mode == 1 && res) || fl_last);
    old_pc = e_pc;
    rs = set_of(m_pc);
    e_vld = fetch;
    if (fetch) begin
      e_pc = m_pc;
      for (int w = 0; w < NW; w++) begin e_vb[w] = m_valid[w][rs]; e_tag[w] = m_tag[w][rs]; end
    end
    if (m_mode == 2) begin
      for (int w = 0; w < NW; w++) m_valid[w][m_cnt] = 0;
      m_cnt++;
    end
    for (int w = 0; w < NW; w++) if (en[w]) begin m_valid[w][st] = 1; m_tag[w][st] = tg; end
    m_pc = br ? tgt : miss_eff ? old_pc : fetch ? m_pc + 32'd4 : m_pc;
    if (to_flush) begin m_mode = 2; m_cnt = 0; m_pend = 0; end
    else if (miss_eff) m_mode = 1;
    else if ((m_mode == 1 && res) || fl_last) m_mode = 0;
    m_started = 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, '0, '0, 0);
  endtask

  task automatic do_reset;
    wb_do_branch = 0; ifd_ift_inf = '0;
`ifdef ICACHE_FLUSH_EN
    flush_req = 0;
`endif
    rst = 0;
    model_reset();
    #1;
    n_tests++;
    if (ift_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", ift_valid); end
    n_tests++;
    if (ift_ifd_inf.valid_bits !== '0) begin n_fail++; $display("FAIL rst_vbits got %b exp 0", ift_ifd_inf.valid_bits); end
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  task automatic test_reset;
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h100; exp_pc[1] = 32'h104; exp_pc[2] = 32'h108;
    do_reset();
    idle(1);
    n_tests++;
    if (ift_valid !== 1'b0) begin n_fail++; $display("FAIL first_edge_valid got %b exp 0", ift_valid); end
    for (int i = 0; i < 3; i++) begin
      idle(1);
      n_tests++;
      if (ift_valid !== 1'b1 || ift_ifd_inf.fetched_pc !== exp_pc[i]) begin
        n_fail++; $display("FAIL reset_seq%0d got v=%b pc=%h exp v=1 pc=%h", i, ift_valid, ift_ifd_inf.fetched_pc, exp_pc[i]);
      end
    end
  endtask

  task automatic test_miss;
    step(1, 32'h200, 0, 0, '0, '0, '0, 0);
    idle(1);
    n_tests++;
    if (ift_valid !== 1'b1 || ift_ifd_inf.fetched_pc !== 32'h200) begin
      n_fail++; $display("FAIL miss_pre got v=%b pc=%h exp v=1 pc=200", ift_valid, ift_ifd_inf.fetched_pc);
    end
    step(0, 0, 1, 0, '0, '0, '0, 0);
    n_tests++;
    if (ift_valid !== 1'b0) begin n_fail++; $display("FAIL miss_valid got %b exp 0", ift_valid); end
    step(0, 0, 0, 0, 2'b01, 6'h10, 21'h15A5A, 0);
    idle(2);
    n_tests++;
    if (ift_valid !== 1'b0) begin n_fail++; $display("FAIL miss_wait_valid got %b exp 0", ift_valid); end
    step(0, 0, 0, 1, '0, '0, '0, 0);
    n_tests++;
    if (ift_valid !== 1'b1 || ift_ifd_inf.fetched_pc !== 32'h200) begin
      n_fail++; $display("FAIL resume_pc got v=%b pc=%h exp v=1 pc=200", ift_valid, ift_ifd_inf.fetched_pc);
    end
    n_tests++;
    if (ift_ifd_inf.valid_bits[0] !== 1'b1 || ift_ifd_inf.tags_read[0] !== 21'h15A5A) begin
      n_fail++; $display("FAIL resume_tag got vb0=%b tag0=%h exp vb0=1 tag0=15a5a", ift_ifd_inf.valid_bits[0], ift_ifd_inf.tags_read[0]);
    end
  endtask

  task automatic test_branch_in_miss;
    idle(1);
    step(0, 0, 1, 0, '0, '0, '0, 0);
    step(1, 32'h400, 0, 0, '0, '0, '0, 0);
    idle(1);
    n_tests++;
    if (ift_valid !== 1'b0) begin n_fail++; $display("FAIL bim_wait got %b exp 0", ift_valid); end
    step(0, 0, 0, 1, '0, '0, '0, 0);
    n_tests++;
    if (ift_valid !== 1'b1 || ift_ifd_inf.fetched_pc !== 32'h400) begin
      n_fail++; $display("FAIL bim_pc got v=%b pc=%h exp v=1 pc=400", ift_valid, ift_ifd_inf.fetched_pc);
    end
  endtask

  task automatic test_branch_miss_same;
    step(1, 32'h300, 0, 0, '0, '0, '0, 0);
    idle(1);
    step(1, 32'h800, 1, 0, '0, '0, '0, 0);
    n_tests++;
    if (ift_valid !== 1'b0) begin n_fail++; $display("FAIL bms_gap got %b exp 0", ift_valid); end
    idle(1);
    n_tests++;
    if (ift_valid !== 1'b1 || ift_ifd_inf.fetched_pc !== 32'h800) begin
      n_fail++; $display("FAIL bms_pc got v=%b pc=%h exp v=1 pc=800", ift_valid, ift_ifd_inf.fetched_pc);
    end
  endtask

  task automatic test_no_bypass;
    step(1, 32'h1040, 0, 0, '0, '0, '0, 0);
    step(0, 0, 0, 0, 2'b10, 6'h02, 21'h01234, 0);
    n_tests++;
    if (ift_valid !== 1'b1 || ift_ifd_inf.valid_bits[1] !== 1'b0) begin
      n_fail++; $display("FAIL bypass_old got v=%b vb1=%b exp v=1 vb1=0", ift_valid, ift_ifd_inf.valid_bits[1]);
    end
    idle(1);
    n_tests++;
    if (ift_ifd_inf.fetched_pc !== 32'h1044 || ift_ifd_inf.valid_bits[1] !== 1'b1 || ift_ifd_inf.tags_read[1] !== 21'h01234) begin
      n_fail++; $display("FAIL bypass_new got pc=%h vb1=%b tag1=%h exp pc=1044 vb1=1 tag1=01234",
                         ift_ifd_inf.fetched_pc, ift_ifd_inf.valid_bits[1], ift_ifd_inf.tags_read[1]);
    end
  endtask

  task automatic test_wrap;
    step(1, 32'hFFFF_FFFC, 0, 0, '0, '0, '0, 0);
    idle(2);
    n_tests++;
    if (ift_valid !== 1'b1 || ift_ifd_inf.fetched_pc !== 32'h0) begin
      n_fail++; $display("FAIL wrap got v=%b pc=%h exp v=1 pc=0", ift_valid, ift_ifd_inf.fetched_pc);
    end
  endtask

`ifdef ICACHE_FLUSH_EN
  task automatic test_flush;
    int busy = 0;
    step(1, 32'h100, 0, 0, 2'b11, 6'h08, 21'h00077, 0);
    step(0, 0, 0, 0, '0, '0, '0, 1);
    while (flush_busy === 1'b1 && busy < 200) begin
      busy++;
      idle(1);
    end
    n_tests++;
    if (busy != 64) begin n_fail++; $display("FAIL flush_len got %0d exp 64", busy); end
    n_tests++;
    if (ift_valid !== 1'b1 || ift_ifd_inf.fetched_pc !== 32'h100 || ift_ifd_inf.valid_bits !== '0) begin
      n_fail++; $display("FAIL flush_after got v=%b pc=%h vb=%b exp v=1 pc=100 vb=0", ift_valid, ift_ifd_inf.fetched_pc, ift_ifd_inf.valid_bits);
    end
  endtask
`endif

  task automatic test_reset_mid_miss;
    step(1, 32'h600, 0, 0, '0, '0, '0, 0);
    idle(1);
    step(0, 0, 1, 0, '0, '0, '0, 0);
    step(0, 0, 0, 0, 2'b11, 6'h08, 21'h00042, 0);
    do_reset();
    idle(2);
    n_tests++;
    if (ift_valid !== 1'b1 || ift_ifd_inf.fetched_pc !== RPC || ift_ifd_inf.valid_bits !== '0) begin
      n_fail++; $display("FAIL rst_miss got v=%b pc=%h vb=%b exp v=1 pc=100 vb=0", ift_valid, ift_ifd_inf.fetched_pc, ift_ifd_inf.valid_bits);
    end
  endtask

  task automatic test_random;
    bit br, miss, res, fl;
    logic [31:0] tgt;
    for (int c = 0; c < 2000; c++) begin
      br   = $urandom_range(0, 9) == 0;
      tgt  = $urandom_range(0, 7) == 0 ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      miss = $urandom_range(0, 3) == 0;
      res  = $urandom_range(0, 2) == 0;
      fl   = $urandom_range(0, 149) == 0;
      step(br, tgt, miss, res,
           $urandom_range(0, 3) == 0 ? NW'($urandom_range(0, (1 << NW) - 1)) : '0,
           ICACHE_NUM_SET_BITS'($urandom_range(0, NS - 1)), ICACHE_TAG_W'($urandom), fl);
      n_tests++;
      if (ift_valid !== e_vld) begin n_fail++; $display("FAIL rnd_valid c=%0d got %b exp %b", c, ift_valid, e_vld); end
`ifdef ICACHE_FLUSH_EN
      n_tests++;
      if (flush_busy !== (m_mode == 2)) begin n_fail++; $display("FAIL rnd_busy c=%0d got %b exp %b", c, flush_busy, m_mode == 2); end
`endif
      if (e_vld) begin
        n_tests++;
        if (ift_ifd_inf.fetched_pc !== e_pc) begin
          n_fail++; $display("FAIL rnd_pc c=%0d got %h exp %h", c, ift_ifd_inf.fetched_pc, e_pc);
        end
        for (int w = 0; w < NW; w++) begin
          n_tests++;
          if (ift_ifd_inf.valid_bits[w] !== e_vb[w]) begin
            n_fail++; $display("FAIL rnd_vb c=%0d w=%0d got %b exp %b", c, w, ift_ifd_inf.valid_bits[w], e_vb[w]);
          end
          if (e_vb[w]) begin
            n_tests++;
            if (ift_ifd_inf.tags_read[w] !== e_tag[w]) begin
              n_fail++; $display("FAIL rnd_tag c=%0d w=%0d got %h exp %h", c, w, ift_ifd_inf.tags_read[w], e_tag[w]);
            end
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_miss();
    test_branch_in_miss();
    test_branch_miss_same();
    test_no_bypass();
    test_wrap();
`ifdef ICACHE_FLUSH_EN
    test_flush();
`endif
    test_reset_mid_miss();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout reached after %0d tests", n_tests);
    $fatal(1, "timeout");
  end
endmodule
